// File: rtl/multu_if.sv
// multu_if: MULTU operation bus from ALU control to the multiplier, plus HI/LO and status back.
interface multu_if #(parameter int WIDTH = 32);
    logic [5:0]       op;
    logic [WIDTH-1:0] src_a;
    logic [WIDTH-1:0] src_b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
    modport master(output op, src_a, src_b, input busy, done, hi, lo);
    modport slave(input op, src_a, src_b, output busy, done, hi, lo);
endinterface

// File: rtl/multu_unit.sv
// multu_unit: sequential radix-2 shift-add 32x32 unsigned multiply / multiply-accumulate owning HI/LO.
module multu_unit #(
    parameter int         WIDTH    = 32,
    parameter logic [5:0] OP_MULTU = 6'b011001,
    parameter logic [5:0] OP_MADDU = 6'b000001
) (
    input logic     clk,
    input logic     rst_n,
    multu_if.slave  bus
);
    localparam int CW = $clog2(WIDTH);
    typedef enum logic [1:0] {IDLE, RUN, WB} state_t;
    state_t             state;
    logic [2*WIDTH:0]   prod;
    logic [WIDTH-1:0]   mcand;
    logic [CW-1:0]      count;
    logic               mode;
    logic               armed;
    logic               req;
    logic               start;
    logic [WIDTH:0]     upper;
    logic [2*WIDTH-1:0] result;
    always_comb begin
        req    = (bus.op == OP_MULTU) || (bus.op == OP_MADDU);
        start  = (state == IDLE) && req && armed;
        upper  = prod[0] ? {1'b0, prod[2*WIDTH-1:WIDTH]} + {1'b0, mcand} : prod[2*WIDTH:WIDTH];
        result = mode ? {bus.hi, bus.lo} + prod[2*WIDTH-1:0] : prod[2*WIDTH-1:0];
    end
    // armed re-arms only once op drops to non-request, so a held request starts one operation
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            prod     <= '0;
            mcand    <= '0;
            count    <= '0;
            mode     <= 1'b0;
            armed    <= 1'b1;
            bus.busy <= 1'b0;
            bus.done <= 1'b0;
            bus.hi   <= '0;
            bus.lo   <= '0;
        end else begin
            bus.done <= 1'b0;
            armed    <= start ? 1'b0 : (!req ? 1'b1 : armed);
            case (state)
                IDLE: if (start) begin
                    mcand    <= bus.src_a;
                    prod     <= {1'b0, {WIDTH{1'b0}}, bus.src_b};
                    mode     <= (bus.op == OP_MADDU);
                    count    <= '0;
                    bus.busy <= 1'b1;
                    state    <= RUN;
                end
                RUN: begin
                    prod  <= {1'b0, upper, prod[WIDTH-1:1]};
                    count <= count + 1'b1;
                    state <= (count == CW'(WIDTH-1)) ? WB : RUN;
                end
                WB: begin
                    {bus.hi, bus.lo} <= result;
                    bus.done         <= 1'b1;
                    bus.busy         <= 1'b0;
                    state            <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_multu_unit.sv
// tb_multu_unit: scoreboard bench for multu_unit covering MULTU, MADDU, wrap, held requests and mid-run reset.
module tb_multu_unit;
    localparam logic [5:0] OP_MULTU = 6'b011001;
    localparam logic [5:0] OP_MADDU = 6'b000001;
    localparam logic [5:0] OP_NONE  = 6'b111111;
    logic clk = 1'b0;
    logic rst_n;
    int n_cmp = 0;
    int n_bad = 0;
    int done_cnt = 0;
    logic [63:0] model = '0;
    logic [63:0] sb_q[$];
    multu_if #(.WIDTH(32)) bus();
    multu_unit #(.WIDTH(32), .OP_MULTU(OP_MULTU), .OP_MADDU(OP_MADDU)) u_dut (
        .clk(clk), .rst_n(rst_n), .bus(bus.slave)
    );
    always #5 clk = ~clk;
    always @(negedge clk) if (bus.done === 1'b1) done_cnt++;
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, required completion");
        $fatal(1);
    end
    // drive a request for one edge, record the expected HI:LO, then drop to non-request
    task automatic issue(input logic [5:0] o, input logic [31:0] a, input logic [31:0] b);
        bus.op = o;
        bus.src_a = a;
        bus.src_b = b;
        model = (o == OP_MADDU) ? model + 64'(a) * 64'(b) : 64'(a) * 64'(b);
        sb_q.push_back(model);
        @(negedge clk);
        bus.op = OP_NONE;
    endtask
    task automatic wait_done(output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (bus.done !== 1'b1 && n < 100);
    endtask
    task automatic test_reset;
        rst_n = 1'b0;
        bus.op = OP_NONE;
        bus.src_a = '0;
        bus.src_b = '0;
        @(negedge clk);
        @(negedge clk);
        n_cmp++; if (bus.hi !== 32'h0) begin n_bad++; $display("FAIL reset_hi: got %h required %h", bus.hi, 32'h0); end
        n_cmp++; if (bus.lo !== 32'h0) begin n_bad++; $display("FAIL reset_lo: got %h required %h", bus.lo, 32'h0); end
        n_cmp++; if (bus.busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b required 0", bus.busy); end
        n_cmp++; if (bus.done !== 1'b0) begin n_bad++; $display("FAIL reset_done: got %b required 0", bus.done); end
        rst_n = 1'b1;
        @(negedge clk);
    endtask
    task automatic test_multu;
        int n, d0;
        logic [63:0] e;
        #1 d0 = done_cnt;
        issue(OP_MULTU, 32'd7, 32'd6);
        n_cmp++; if (bus.busy !== 1'b1) begin n_bad++; $display("FAIL multu_busy_after_start: got %b required 1", bus.busy); end
        wait_done(n);
        n_cmp++; if (n != 33) begin n_bad++; $display("FAIL multu_latency: got %0d required 33", n); end
        e = sb_q.size() ? sb_q.pop_front() : 'x;
        n_cmp++; if ({bus.hi, bus.lo} !== e) begin n_bad++; $display("FAIL multu_7x6: got %h required %h", {bus.hi, bus.lo}, e); end
        n_cmp++; if (bus.busy !== 1'b0) begin n_bad++; $display("FAIL multu_busy_at_done: got %b required 0", bus.busy); end
        @(negedge clk);
        #1;
        n_cmp++; if (bus.done !== 1'b0) begin n_bad++; $display("FAIL multu_done_width: got %b required 0", bus.done); end
        n_cmp++; if (done_cnt - d0 != 1) begin n_bad++; $display("FAIL multu_done_count: got %0d required 1", done_cnt - d0); end
    endtask
    task automatic test_maddu;
        int n;
        logic [63:0] e;
        issue(OP_MADDU, 32'd3, 32'd5);
        wait_done(n);
        e = sb_q.size() ? sb_q.pop_front() : 'x;
        n_cmp++; if ({bus.hi, bus.lo} !== e) begin n_bad++; $display("FAIL maddu_3x5: got %h required %h", {bus.hi, bus.lo}, e); end
        n_cmp++; if (bus.lo !== 32'h39) begin n_bad++; $display("FAIL maddu_lo_const: got %h required %h", bus.lo, 32'h39); end
    endtask
    task automatic test_carry;
        int n;
        logic [63:0] e;
        issue(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        bus.src_a = 32'h1234_5678;
        bus.src_b = 32'h0BAD_F00D;
        wait_done(n);
        e = sb_q.size() ? sb_q.pop_front() : 'x;
        n_cmp++; if ({bus.hi, bus.lo} !== e) begin n_bad++; $display("FAIL carry_ffxff: got %h required %h", {bus.hi, bus.lo}, e); end
        n_cmp++; if (bus.hi !== 32'hFFFF_FFFE) begin n_bad++; $display("FAIL carry_hi: got %h required %h", bus.hi, 32'hFFFF_FFFE); end
    endtask
    task automatic test_back_to_back;
        int n;
        logic [63:0] e;
        issue(OP_MADDU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        wait_done(n);
        n_cmp++; if (n != 33) begin n_bad++; $display("FAIL wrap_latency: got %0d required 33", n); end
        e = sb_q.size() ? sb_q.pop_front() : 'x;
        n_cmp++; if ({bus.hi, bus.lo} !== e) begin n_bad++; $display("FAIL wrap_maddu: got %h required %h", {bus.hi, bus.lo}, e); end
        n_cmp++; if ({bus.hi, bus.lo} !== 64'hFFFF_FFFC_0000_0002) begin n_bad++; $display("FAIL wrap_const: got %h required %h", {bus.hi, bus.lo}, 64'hFFFF_FFFC_0000_0002); end
        @(negedge clk);
    endtask
    task automatic test_held;
        int n, d0;
        logic [63:0] e;
        #1 d0 = done_cnt;
        bus.op = OP_MULTU;
        bus.src_a = 32'd2;
        bus.src_b = 32'd3;
        model = 64'd6;
        sb_q.push_back(model);
        repeat (40) @(negedge clk);
        #1;
        n_cmp++; if (done_cnt - d0 != 1) begin n_bad++; $display("FAIL held_done_count: got %0d required 1", done_cnt - d0); end
        n_cmp++; if (bus.busy !== 1'b0) begin n_bad++; $display("FAIL held_busy_after: got %b required 0", bus.busy); end
        e = sb_q.size() ? sb_q.pop_front() : 'x;
        n_cmp++; if ({bus.hi, bus.lo} !== e) begin n_bad++; $display("FAIL held_2x3: got %h required %h", {bus.hi, bus.lo}, e); end
        bus.op = OP_NONE;
        @(negedge clk);
        bus.op = OP_MULTU;
        bus.src_a = 32'd11;
        bus.src_b = 32'd13;
        model = 64'd143;
        sb_q.push_back(model);
        @(negedge clk);
        bus.op = OP_NONE;
        n_cmp++; if (bus.busy !== 1'b1) begin n_bad++; $display("FAIL rearm_start: got busy %b required 1", bus.busy); end
        wait_done(n);
        e = sb_q.size() ? sb_q.pop_front() : 'x;
        n_cmp++; if ({bus.hi, bus.lo} !== e) begin n_bad++; $display("FAIL rearm_11x13: got %h required %h", {bus.hi, bus.lo}, e); end
        @(negedge clk);
    endtask
    task automatic test_reset_mid;
        int n, d0;
        logic [63:0] e;
        issue(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        repeat (15) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        n_cmp++; if (bus.busy !== 1'b0) begin n_bad++; $display("FAIL midreset_busy: got %b required 0", bus.busy); end
        n_cmp++; if ({bus.hi, bus.lo} !== 64'h0) begin n_bad++; $display("FAIL midreset_hilo: got %h required %h", {bus.hi, bus.lo}, 64'h0); end
        sb_q.delete();
        model = '0;
        d0 = done_cnt;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (40) @(negedge clk);
        #1;
        n_cmp++; if (done_cnt != d0) begin n_bad++; $display("FAIL midreset_no_done: got %0d pulses required 0", done_cnt - d0); end
        n_cmp++; if (bus.busy !== 1'b0) begin n_bad++; $display("FAIL midreset_idle: got busy %b required 0", bus.busy); end
        issue(OP_MULTU, 32'd1, 32'd9);
        wait_done(n);
        e = sb_q.size() ? sb_q.pop_front() : 'x;
        n_cmp++; if ({bus.hi, bus.lo} !== e) begin n_bad++; $display("FAIL after_reset_1x9: got %h required %h", {bus.hi, bus.lo}, e); end
    endtask
    initial begin
        test_reset();
        test_multu();
        test_maddu();
        test_carry();
        test_back_to_back();
        test_held();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
